// File: rtl/round_builder_if.sv
// round_builder_if: control inputs and pattern/entry outputs of the round builder.
interface round_builder_if;
  logic start;
  logic [3:0] btn;
  logic next;
  logic [63:0] pattern;
  logic [63:0] entry;
  logic load;
  logic [5:0] round;
  logic done;
  modport master (output start, btn, next, input pattern, entry, load, round, done);
  modport slave (input start, btn, next, output pattern, entry, load, round, done);
endinterface

// File: rtl/round_builder.sv
// round_builder: grows a 2-bit-per-symbol secret pattern each round and collects matching button entries.
// Defining ROUND_BUILDER_FIXED_SEQ_EN replaces the LFSR symbol with round[1:0].
module round_builder #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int MAX_ROUND = 32
) (
  input logic clk,
  input logic rst_n,
  round_builder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, EXTEND, COLLECT, LOAD, WAIT, DONE} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [63:0] pattern, entry;
  logic [5:0] round, count, count_nx;
  logic load, done, valid;
  logic [1:0] sym, code;
  // exactly one button bit set counts as a press
  assign valid = (bus.btn != 4'd0) && ((bus.btn & (bus.btn - 4'd1)) == 4'd0);
  assign code = {bus.btn[3] | bus.btn[2], bus.btn[3] | bus.btn[1]};
  assign count_nx = count + 6'd1;
`ifdef ROUND_BUILDER_FIXED_SEQ_EN
  assign sym = round[1:0];
`else
  assign sym = lfsr[1:0];
`endif
  assign bus.pattern = pattern;
  assign bus.entry = entry;
  assign bus.load = load;
  assign bus.round = round;
  assign bus.done = done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pattern <= '0;
      entry <= '0;
      round <= '0;
      count <= '0;
      load <= 1'b0;
      done <= 1'b0;
    end else begin
      load <= 1'b0;
      if (bus.start) begin
        state <= EXTEND;
        pattern <= '0;
        entry <= '0;
        round <= '0;
        count <= '0;
        done <= 1'b0;
      end else begin
        case (state)
          EXTEND: begin
            pattern <= {pattern[61:0], sym};
            round <= round + 6'd1;
            entry <= '0;
            count <= '0;
            state <= COLLECT;
          end
          COLLECT: if (valid) begin
            entry <= {entry[61:0], code};
            count <= count_nx;
            if (count_nx == round) state <= LOAD;
          end
          LOAD: begin
            load <= 1'b1;
            state <= WAIT;
          end
          WAIT: if (bus.next) begin
            state <= (round == 6'(MAX_ROUND)) ? DONE : EXTEND;
            done <= (round == 6'(MAX_ROUND));
          end
          default: ;
        endcase
      end
    end
  end
endmodule
